// File: rtl/cdb_arbiter.sv
// cdb_arbiter: grants up to two finished execution-unit results per cycle onto
// the two common data buses (cdb[0], cdb[1]) using rotating round-robin priority.
// It is the only writer of both buses. Granted results appear on the buses one
// cycle after the grant, for exactly one cycle.
//
// Optional build macro: CDB_AGING_EN
//   When defined, each requester gets a 4-bit saturating wait counter. A requester
//   whose counter reaches AGE_LIMIT takes bus 0 ahead of round-robin order.
//   When undefined, the arbiter is pure round-robin and AGE_LIMIT is ignored.
//
// Ports:
//   clk          clock, all state on the rising edge
//   reset        synchronous active-high reset
//   flush        pipeline flush: no grants this cycle, buses idle next cycle
//   req_valid    per-requester result-ready flag
//   req_data     per-requester result value
//   req_address  per-requester instruction address
//   req_rrn      per-requester destination rename register
//   req_tag      per-requester speculation tag
//   req_grant    combinational grant, at most two bits set
//   cdb_valid    per-bus valid (registered)
//   cdb_data     per-bus result value (registered)
//   cdb_address  per-bus instruction address (registered)
//   cdb_rrn      per-bus rename register (registered)
//   cdb_tag      per-bus speculation tag (registered)

module cdb_arbiter #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned REQS      = 4,
  parameter int unsigned AGE_LIMIT = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [REQS-1:0]               req_valid,
  input  logic [REQS-1:0][XLEN-1:0]     req_data,
  input  logic [REQS-1:0][XLEN-1:0]     req_address,
  input  logic [REQS-1:0][5:0]          req_rrn,
  input  logic [REQS-1:0]               req_tag,
  output logic [REQS-1:0]               req_grant,
  output logic [1:0]                    cdb_valid,
  output logic [1:0][XLEN-1:0]          cdb_data,
  output logic [1:0][XLEN-1:0]          cdb_address,
  output logic [1:0][5:0]               cdb_rrn,
  output logic [1:0]                    cdb_tag
);

  localparam int unsigned PTR_W = $clog2(REQS);
  // One extra bit so ptr + offset never overflows before the modulo fold.
  localparam int unsigned IDX_W = PTR_W + 1;
  localparam int unsigned AGE_W = 4;

  // Rotation pointer: requester with highest round-robin priority.
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_nxt;

  // First and second valid requesters in round-robin order from ptr.
  logic             rr0_vld;
  logic             rr1_vld;
  logic [PTR_W-1:0] rr0_idx;
  logic [PTR_W-1:0] rr1_idx;
  logic [IDX_W-1:0] cand;

  // Final bus selections after aging and flush/reset suppression.
  logic             g0_vld;
  logic             g1_vld;
  logic [PTR_W-1:0] g0_idx;
  logic [PTR_W-1:0] g1_idx;

  // Next index after i, wrapping at REQS (REQS need not be a power of two).
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] i);
    if (i == PTR_W'(REQS - 1)) begin
      return '0;
    end
    return i + PTR_W'(1);
  endfunction

  // Round-robin scan starting at ptr.
  always_comb begin : rr_scan
    rr0_vld = 1'b0;
    rr1_vld = 1'b0;
    rr0_idx = '0;
    rr1_idx = '0;
    cand    = '0;
    for (int unsigned off = 0; off < REQS; off++) begin
      cand = IDX_W'(ptr) + IDX_W'(off);
      if (cand >= IDX_W'(REQS)) begin
        cand = cand - IDX_W'(REQS);
      end
      if (req_valid[cand[PTR_W-1:0]]) begin
        if (!rr0_vld) begin
          rr0_vld = 1'b1;
          rr0_idx = cand[PTR_W-1:0];
        end else if (!rr1_vld) begin
          rr1_vld = 1'b1;
          rr1_idx = cand[PTR_W-1:0];
        end
      end
    end
  end

`ifdef CDB_AGING_EN
  // Per-requester wait counters and the starvation-boost candidate.
  logic [REQS-1:0][AGE_W-1:0] age;
  logic                       boost_vld;
  logic [PTR_W-1:0]           boost_idx;

  // Lowest-index requester whose wait reached AGE_LIMIT.
  always_comb begin : boost_pick
    boost_vld = 1'b0;
    boost_idx = '0;
    for (int unsigned i = 0; i < REQS; i++) begin
      if (!boost_vld && req_valid[i] && (age[i] >= AGE_W'(AGE_LIMIT))) begin
        boost_vld = 1'b1;
        boost_idx = PTR_W'(i);
      end
    end
  end

  // Bus selection: a boosted requester displaces round-robin on bus 0; bus 1
  // takes the first other valid requester in round-robin order.
  always_comb begin : bus_select
    g0_vld  = rr0_vld;
    g0_idx  = rr0_idx;
    g1_vld  = rr1_vld;
    g1_idx  = rr1_idx;
    ptr_nxt = ptr;
    if (boost_vld) begin
      g0_vld = 1'b1;
      g0_idx = boost_idx;
      if (rr0_vld && (rr0_idx != boost_idx)) begin
        g1_vld = 1'b1;
        g1_idx = rr0_idx;
      end else begin
        g1_vld = rr1_vld;
        g1_idx = rr1_idx;
      end
      // A boost grant alone leaves the rotation where it was.
      if (g1_vld) begin
        ptr_nxt = wrap_inc(g1_idx);
      end
    end else if (rr1_vld) begin
      ptr_nxt = wrap_inc(rr1_idx);
    end else if (rr0_vld) begin
      ptr_nxt = wrap_inc(rr0_idx);
    end
    if (flush || reset) begin
      g0_vld  = 1'b0;
      g1_vld  = 1'b0;
      ptr_nxt = ptr;
    end
  end

  // Wait counters: count un-granted valid cycles, saturate, hold across flush.
  always_ff @(posedge clk) begin : age_regs
    if (reset) begin
      age <= '0;
    end else if (!flush) begin
      for (int unsigned i = 0; i < REQS; i++) begin
        if (!req_valid[i] || req_grant[i]) begin
          age[i] <= '0;
        end else if (age[i] != {AGE_W{1'b1}}) begin
          age[i] <= age[i] + AGE_W'(1);
        end
      end
    end
  end
`else
  // AGE_LIMIT has no meaning without aging; fold it into an ignored signal.
  logic unused_age_limit;
  assign unused_age_limit = |AGE_W'(AGE_LIMIT);

  // Bus selection: pure round-robin, pointer follows the last grant.
  always_comb begin : bus_select
    g0_vld  = rr0_vld;
    g0_idx  = rr0_idx;
    g1_vld  = rr1_vld;
    g1_idx  = rr1_idx;
    ptr_nxt = ptr;
    if (rr1_vld) begin
      ptr_nxt = wrap_inc(rr1_idx);
    end else if (rr0_vld) begin
      ptr_nxt = wrap_inc(rr0_idx);
    end
    if (flush || reset) begin
      g0_vld  = 1'b0;
      g1_vld  = 1'b0;
      ptr_nxt = ptr;
    end
  end
`endif

  // Grant vector: union of the two bus selections.
  always_comb begin : grant_vec
    req_grant = '0;
    for (int unsigned i = 0; i < REQS; i++) begin
      req_grant[i] = (g0_vld && (g0_idx == PTR_W'(i))) ||
                     (g1_vld && (g1_idx == PTR_W'(i)));
    end
  end

  // Rotation pointer and bus output registers. Idle buses keep stale payload.
  always_ff @(posedge clk) begin : bus_regs
    if (reset) begin
      ptr         <= '0;
      cdb_valid   <= '0;
      cdb_data    <= '0;
      cdb_address <= '0;
      cdb_rrn     <= '0;
      cdb_tag     <= '0;
    end else begin
      ptr       <= ptr_nxt;
      cdb_valid <= {g1_vld, g0_vld};
      if (g0_vld) begin
        cdb_data[0]    <= req_data[g0_idx];
        cdb_address[0] <= req_address[g0_idx];
        cdb_rrn[0]     <= req_rrn[g0_idx];
        cdb_tag[0]     <= req_tag[g0_idx];
      end
      if (g1_vld) begin
        cdb_data[1]    <= req_data[g1_idx];
        cdb_address[1] <= req_address[g1_idx];
        cdb_rrn[1]     <= req_rrn[g1_idx];
        cdb_tag[1]     <= req_tag[g1_idx];
      end
    end
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Arbitrates completed results from REQS execution units onto the two common data buses (cdb[0], cdb[1]) that feed the reservation stations, register file and reorder logic. Each cycle it grants up to two waiting requesters with rotating round-robin priority and drives their results onto the buses one cycle later. It is the single writer of both CDBs and sits between the execution units' result registers and all CDB listeners.

## Interface
- XLEN, 32, data/address width
- REQS, 4, number of requesting execution units (2..8)
- AGE_LIMIT, 8, wait cycles before starvation boost (only with CDB_AGING_EN; 1..15)

Ports:
- gsi.clk  input  1  clock; single clock domain, all state on rising edge
- gsi.reset  input  1  synchronous, active-high reset
- flush  input  1  pipeline flush; suppresses all grants this cycle and clears bus outputs
- req_valid  input  REQS  requester i holds a finished result
- req_data  input  REQS×XLEN  result value
- req_address  input  REQS×XLEN  instruction address
- req_rrn  input  REQS×6  destination rename register
- req_tag  input  REQS  speculation tag
- req_grant  output  REQS  one-hot-or-two-hot; requester i's result accepted this cycle
- cdb_valid  output  2  bus k carries a result
- cdb_data, cdb_address  output  2×XLEN  per-bus result, address
- cdb_rrn  output  2×6  per-bus rename register
- cdb_tag  output  2  per-bus tag

## Operation
- Handshake: requester asserts req_valid with stable payload; holds both until the cycle req_grant[i]=1; may drop or present a new result the next cycle. Grant without valid never occurs.
- State: rotation pointer ptr (clog2(REQS) bits); bus output registers; per-requester wait counters when aging is enabled.
- Selection (flush=0): scan i = ptr, ptr+1, … mod REQS; first valid → bus 0, second valid → bus 1. Fewer than two valid → unused bus idle.
- Bus assignment is positional: bus 0 always gets the higher-priority grant. Bus 1 is never used while bus 0 is idle.
- Pointer update: ptr ← (index of last-granted requester + 1) mod REQS; unchanged when nothing granted or flush=1.
- Bus registers load payload of granted requesters; idle bus loads cdb_valid=0 (payload fields hold last value, don't-care).
- flush=1: req_grant=0, cdb_valid ← 0 next cycle, ptr and counters unchanged. Requesters are responsible for discarding their own flushed results.
- Reset: ptr=0, cdb_valid=0, cdb_data/address=0, cdb_rrn=0, cdb_tag=0, counters=0; req_grant forced 0 while gsi.reset=1.

## Timing
- req_grant combinational from req_valid, ptr, flush (and counters) in the same cycle.
- CDB latency: granted in cycle t → cdb_valid/payload visible in cycle t+1, for exactly one cycle.
- Throughput: 2 results/cycle sustained; a requester holding valid continuously under full load is granted at least once every ceil(REQS/2) cycles.
- Reset asserted mid-transfer: bus outputs cleared the following edge; granted-but-unbroadcast result is lost (acceptable, reset discards pipeline).
- Flush in cycle t while bus holds a result from t-1: that result is still visible in t; t+1 shows cdb_valid=0.

## Configuration
- CDB_AGING_EN defined: per-requester 4-bit saturating counter increments each cycle req_valid=1 and req_grant=0, clears on grant or when req_valid=0. Any requester with counter ≥ AGE_LIMIT takes bus 0 (lowest index among such); bus 1 goes to the first other valid requester in round-robin order; ptr updates from the bus-1 grant if present, else unchanged.
- Not defined: pure round-robin as above; no counters synthesized, AGE_LIMIT ignored.

## Test plan
- Reset then req_valid=4'b1111, all held: cycle 0 grants 0,1; cycle 1 grants 2,3; cycle 2 grants 0,1; cdb_rrn matches one cycle after each grant.
- Single requester: req_valid=4'b0100, rrn=6'd17, data=32'hDEAD_BEEF → req_grant=4'b0100, next cycle cdb_valid=2'b01, cdb_data[0]=32'hDEAD_BEEF, cdb_rrn[0]=17, ptr=3.
- ptr=3, req_valid=4'b1001 → bus 0 = requester 3, bus 1 = requester 0, ptr←1.
- flush=1 with req_valid=4'b0011 → req_grant=0, next cycle cdb_valid=0, ptr unchanged; flush=0 next cycle grants 0,1.
- gsi.reset asserted one cycle after grant of requester 2 → next edge cdb_valid=0, ptr=0, all outputs zero.
- CDB_AGING_EN, AGE_LIMIT=2, REQS=4, requesters 0,1,2 permanently valid and requester 3 pulsed late → requester 3 granted on bus 0 no later than its second waiting cycle; counter clears after grant.
